// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: IF/ID register, field/immediate decode and a
// 32-entry busy scoreboard that holds back issue on read-after-write hazards.
module decode_issue_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd
);

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic            id_valid_reg;
  logic [31:0]     id_instr_reg;
  logic [XLEN-1:0] id_pc_reg;
  logic [31:0]     busy;

  logic rs1_used;
  logic rs2_used;
  logic writes_rd;
  logic hazard;
  logic issue;

  assign opcode   = id_instr_reg[6:0];
  assign rd_addr  = id_instr_reg[11:7];
  assign funct3   = id_instr_reg[14:12];
  assign rs1_addr = id_instr_reg[19:15];
  assign rs2_addr = id_instr_reg[24:20];
  assign funct7   = id_instr_reg[31:25];
  assign out_pc   = id_pc_reg;

  always_comb begin
    imm       = '0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm       = {id_instr_reg[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm       = {{11{id_instr_reg[31]}}, id_instr_reg[31], id_instr_reg[19:12],
                     id_instr_reg[20], id_instr_reg[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        imm       = {{20{id_instr_reg[31]}}, id_instr_reg[31:20]};
        rs1_used  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE: begin
        imm      = {{20{id_instr_reg[31]}}, id_instr_reg[31:25], id_instr_reg[11:7]};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{id_instr_reg[31]}}, id_instr_reg[31], id_instr_reg[7],
                    id_instr_reg[30:25], id_instr_reg[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_OP: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign reg_write = writes_rd && (rd_addr != 5'd0);
  assign hazard    = (rs1_used && busy[rs1_addr]) || (rs2_used && busy[rs2_addr]);
  assign out_valid = id_valid_reg && !hazard && !flush;
  assign issue     = out_valid && out_ready;
  assign in_ready  = !RESET && !flush && (!id_valid_reg || issue);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      id_valid_reg <= 1'b0;
      id_instr_reg <= '0;
      id_pc_reg    <= '0;
    end else if (flush) begin
      id_valid_reg <= 1'b0;
    end else if (in_valid && in_ready) begin
      id_valid_reg <= 1'b1;
      id_instr_reg <= in_instr;
      id_pc_reg    <= in_pc;
    end else if (issue) begin
      id_valid_reg <= 1'b0;
    end
  end

  // Setting has priority over clearing: a newly issued writer is still pending.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy[gi] = 1'b0;
      end else begin : g_bit
        always_ff @(posedge CLK) begin
          if (RESET)
            busy[gi] <= 1'b0;
          else if (issue && reg_write && (rd_addr == 5'(gi)))
            busy[gi] <= 1'b1;
          else if (wb_valid && (wb_rd == 5'(gi)))
            busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: expected decodes are queued when an
// instruction is offered and compared when the stage issues it.
module tb_decode_issue_stage;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        reg_write;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  decode_issue_stage dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm),
    .reg_write(reg_write), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [23:0] fields;  // {opcode, rd, rs1, rs2, reg_write, illegal}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one instruction; returns at posedge+1 right after it was captured.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bit push,
                      input logic [6:0] e_opc, input logic [4:0] e_rd,
                      input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                      input logic [31:0] e_imm, input logic e_rw, input logic e_ill);
    exp_t e;
    bit   ok;
    e.pc     = pc;
    e.imm    = e_imm;
    e.fields = {e_opc, e_rd, e_rs1, e_rs2, e_rw, e_ill};
    if (push) exp_q.push_back(e);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      ok = in_ready;
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
    @(negedge CLK);
    chk("no_bypass", 64'(out_valid), 64'd0);
    tick();
    wb_valid = 1'b0;
  endtask

  // Compare every issued instruction against the oldest expectation.
  always @(negedge CLK) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {32'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("issue pc=%h opcode=%b rd=%0d rs1=%0d rs2=%0d imm=%h rw=%b ill=%b",
                 out_pc, opcode, rd_addr, rs1_addr, rs2_addr, imm, reg_write, illegal);
        chk("pc", 64'(out_pc), 64'(e.pc));
        chk("imm", 64'(imm), 64'(e.imm));
        chk("fields", 64'({opcode, rd_addr, rs1_addr, rs2_addr, reg_write, illegal}),
            64'(e.fields));
      end
    end
  end

  initial begin
    RESET = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    repeat (2) tick();
    @(negedge CLK);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pc_imm", {out_pc, imm}, 64'd0);
    chk("rst_fields", 64'({opcode, rd_addr, rs1_addr, rs2_addr, reg_write, illegal}), 64'd1);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // addi x1,x0,5 then dependent add x2,x1,x2
    send(32'h00500093, 32'h100, 1, 7'h13, 5'd1, 5'd0, 5'd5, 32'd5, 1'b1, 1'b0);
    @(negedge CLK);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    tick();
    send(32'h00208133, 32'h104, 1, 7'h33, 5'd2, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("raw_stall_ov", 64'(out_valid), 64'd0);
      chk("raw_stall_ir", 64'(in_ready), 64'd0);
      tick();
    end
    writeback(5'd1);
    @(negedge CLK);
    chk("after_wb_ov", 64'(out_valid), 64'd1);
    tick();

    // sw x2,-4(x1) waits on x2; then back-to-back beq, addi x0, illegal
    send(32'hFE20AE23, 32'h108, 1, 7'h23, 5'd28, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b0);
    @(negedge CLK);
    chk("sw_stall_ov", 64'(out_valid), 64'd0);
    tick();
    writeback(5'd2);
    send(32'hFE000CE3, 32'h10C, 1, 7'h63, 5'd25, 5'd0, 5'd0, 32'hFFFFFFF8, 1'b0, 1'b0);
    send(32'h00100013, 32'h110, 1, 7'h13, 5'd0, 5'd0, 5'd1, 32'd1, 1'b0, 1'b0);
    send(32'h0000007F, 32'h114, 1, 7'h7F, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
    @(negedge CLK);
    chk("illegal_no_stall", 64'(out_valid), 64'd1);
    tick();

    // lui x1 then a held x1 consumer that gets flushed
    send(32'h123450B7, 32'h118, 1, 7'h37, 5'd1, 5'd8, 5'd3, 32'h12345000, 1'b1, 1'b0);
    send(32'h00208133, 32'h11C, 0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100013; in_pc = 32'h200;
    @(negedge CLK);
    chk("flush_ov", 64'(out_valid), 64'd0);
    chk("flush_ir", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    chk("flush_empty_ov", 64'(out_valid), 64'd0);
    chk("flush_empty_ir", 64'(in_ready), 64'd1);
    tick();
    send(32'hFE20AE23, 32'h120, 1, 7'h23, 5'd28, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b0);
    @(negedge CLK);
    chk("busy_kept_ov", 64'(out_valid), 64'd0);
    tick();
    writeback(5'd1);

    // jal x3 issues in the same cycle x3 is written back: x3 stays busy
    send(32'h008001EF, 32'h124, 1, 7'h6F, 5'd3, 5'd0, 5'd8, 32'd8, 1'b1, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge CLK);
    chk("jal_ov", 64'(out_valid), 64'd1);
    tick();
    wb_valid = 1'b0;
    send(32'h00318233, 32'h128, 1, 7'h33, 5'd4, 5'd3, 5'd3, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("set_wins_ov", 64'(out_valid), 64'd0);
      tick();
    end
    writeback(5'd3);
    tick();

    // reset in the middle of a stall on x4 drops the instruction and busy bits
    send(32'h00020113, 32'h12C, 0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("x4_stall_ov", 64'(out_valid), 64'd0);
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_ir", 64'(in_ready), 64'd0);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    tick();
    send(32'h00020113, 32'h130, 1, 7'h13, 5'd2, 5'd4, 5'd0, 32'd0, 1'b1, 1'b0);
    @(negedge CLK);
    chk("busy_cleared_ov", 64'(out_valid), 64'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
